usb_tx_sequencer: RTL
=====================

Name: usb_tx_sequencer

Overview:
- Packet-level transmit controller that sequences the NRZI line encoder: drives its `data_in` and `en_nrzi` inputs, plus an SE0 request to the pad driver.
- Accepts payload bytes over a valid/ready handshake. Emits SYNC, payload LSB-first with bit stuffing, optional CRC16, then EOP (SE0, then idle).
- Sits between the packet assembler and `en_nrzi`; the line rate is derived from `clk` by a bit-period divider.

Parameters:
- CLK_DIV, 4, clocks per bit period (>=2)
- STUFF_LEN, 6, consecutive 1-bits after which a 0 is stuffed
- EOP_SE0_BITS, 2, SE0 length of EOP in bit periods

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- tx_start  in  1  start-of-packet pulse; ignored while tx_busy
- tx_data  in  8  payload byte
- tx_valid  in  1  tx_data valid
- tx_last  in  1  qualifies tx_data as final payload byte
- tx_ready  out  1  byte accepted when tx_valid & tx_ready
- data_out  out  1  logical bit to encoder data_in (1 = no transition)
- en_nrzi  out  1  encoder enable; high for SYNC/payload/CRC bits
- tx_se0  out  1  SE0 request to pad driver during EOP
- tx_busy  out  1  high from cycle after accepted tx_start until tx_done
- tx_done  out  1  one-cycle pulse at end of EOP
- tx_underrun  out  1  one-cycle pulse when payload starves

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. All outputs 0, holding register empty, counters 0. Applies mid-packet: the line drops to encoder idle with no EOP.
- States: IDLE -> SYNC -> DATA -> [CRC] -> EOP_SE0 -> EOP_J -> IDLE.
- Bit timer:
  - Counts 0..CLK_DIV-1 and restarts on entry to SYNC.
  - Each bit is held on data_out/en_nrzi/tx_se0 for exactly CLK_DIV clocks.
  - State and bit advance on the last clock of a period.
- Start timing: tx_start accepted in IDLE at cycle N makes the first SYNC bit appear at N+1.
- SYNC: 8 bits 0,0,0,0,0,0,0,1 (0x80 sent LSB-first).
- Payload holding register:
  - One byte deep; tx_ready = (SYNC or DATA) & empty & !last_accepted.
  - The shifter loads from the holding register at each byte boundary. Back-to-back bytes therefore have no gap.
- Underrun:
  - Condition: a byte boundary is reached (end of SYNC or of a byte), the holding register is empty, and tx_last has not been accepted.
  - Response: pulse tx_underrun, go straight to EOP_SE0. No CRC; the pending stuff bit is dropped.
- Bit stuffing:
  - The ones counter counts consecutive transmitted 1s across SYNC, payload and CRC, and clears on any 0.
  - When it reaches STUFF_LEN, the next bit period sends 0 with en_nrzi=1. The payload bit is not consumed and the counter clears.
  - A stuff bit due after the final payload or CRC bit is sent before EOP.
- EOP_SE0: EOP_SE0_BITS periods with en_nrzi=0, tx_se0=1, data_out=0.
- EOP_J: one period with en_nrzi=0, tx_se0=0 (encoder idles J).
- tx_done pulses the cycle after EOP_J ends, with tx_busy falling the same cycle.
- tx_start while busy is ignored. tx_valid outside SYNC/DATA is ignored.

Optional Feature:
- Macro: USB_TX_CRC16_EN.
- Defined: after the last payload bit, the CRC state runs 16 bits of CRC, stuffed like payload.
  - CRC is CRC-16/USB: reflected poly 0xA001 (0x8005), init 0xFFFF, xorout 0xFFFF.
  - Computed over payload bits in transmit order; sent LSB-first (low byte first).
- Undefined: the CRC state and logic are absent; DATA goes directly to EOP_SE0.

Decomposition:
- Package usb_tx_pkg:
  - state enum (IDLE, SYNC, DATA, CRC, EOP_SE0, EOP_J)
  - SYNC_PATTERN = 8'h80
  - CRC16_POLY_REFL = 16'hA001
  - CRC16_INIT = 16'hFFFF
- Sub-module usb_crc16_ser:
  - serial CRC with clear, bit_valid, bit_in and a 16-bit result
  - instantiated only under USB_TX_CRC16_EN

Test Plan:
1. Single byte. CLK_DIV=4, tx_start at N, byte 0x00 with tx_last.
   - Bits: 0000000100000000 from N+1.
   - tx_se0 high N+65..N+72, J N+73..N+76.
   - tx_done at N+77; tx_busy low at N+77.
2. Stuffing. Byte 0xFF with tx_last.
   - After SYNC's final 1 plus five data 1s, a 0 is inserted, then the remaining three 1s.
   - 17 bit periods with en_nrzi=1 before SE0.
3. Back-to-back. Bytes 0xA5, then 0x3C with tx_last, valid held high.
   - Two handshakes occur, with no idle period between bytes.
   - Line bits are 10100101 then 00111100, LSB-first.
4. Underrun. tx_start with tx_valid never asserted.
   - tx_underrun pulses at the end of SYNC, followed by SE0 for 2 periods, J, then tx_done.
5. Reset mid-DATA. rst=0 for one clock during byte 2.
   - At the next edge all outputs are 0 and the state is IDLE.
   - A new tx_start afterwards produces a clean SYNC.
6. CRC (USB_TX_CRC16_EN). Payload "123456789" (0x31..0x39).
   - CRC bytes 0xC8 then 0xB4 follow the payload, stuffed where required, then EOP.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB packet transmit sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, CRC, EOP_SE0, EOP_J
  } tx_state_e;

  localparam logic [7:0]  SYNC_PATTERN    = 8'h80;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

  // One serial step of the reflected CRC-16, data bit taken in transmit order.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return (crc >> 1) ^ ((crc[0] ^ b) ? CRC16_POLY_REFL : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_tx_sequencer_crc.sv
// Serial CRC-16/USB accumulator; result is the raw register (xorout applied by the caller).
module usb_crc16_ser
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        bit_valid_i,
  input  logic        bit_in_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  always_ff @(posedge clk) begin
    if (!rst)             crc_q <= CRC16_INIT;
    else if (clr_i)       crc_q <= CRC16_INIT;
    else if (bit_valid_i) crc_q <= crc16_step(crc_q, bit_in_i);
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB packet transmit sequencer: SYNC, stuffed payload, optional CRC16, EOP.
// Optional CRC16 trailer enabled by defining USB_TX_CRC16_EN.
module usb_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       data_out,
  output logic       en_nrzi,
  output logic       tx_se0,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int OW = $clog2(STUFF_LEN + 1);

  tx_state_e    state_q, state_d, nxt_state;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]   bidx_q, bidx_d, nxt_idx, unit_len;
  logic [15:0]  shift_q, shift_d;
  logic [7:0]   hold_q, hold_d;
  logic         hold_vld_q, hold_vld_d, last_acc_q, last_acc_d;
  logic [OW-1:0] ones_q, ones_d;
  logic         dout_q, dout_d, en_q, en_d, se0_q, se0_d;
  logic         busy_q, busy_d, done_q, done_d, undr_q, undr_d;
  logic         boundary, stuff, fin, to_eop, bit_v;

`ifdef USB_TX_CRC16_EN
  logic        crc_clr, crc_bv, crc_bit;
  logic [15:0] crc_val;

  usb_crc16_ser u_crc (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (crc_clr),
    .bit_valid_i (crc_bv),
    .bit_in_i    (crc_bit),
    .crc_o       (crc_val)
  );
`endif

  assign tx_ready = (state_q == SYNC || state_q == DATA) && !hold_vld_q && !last_acc_q;
  assign boundary = (cnt_q == CW'(CLK_DIV - 1));
  assign stuff    = (ones_q == OW'(STUFF_LEN));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bidx_d     = bidx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    last_acc_d = last_acc_q;
    ones_d     = ones_q;
    dout_d     = dout_q;
    en_d       = en_q;
    se0_d      = se0_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    undr_d     = 1'b0;
    nxt_state  = state_q;
    nxt_idx    = bidx_q;
    fin        = 1'b0;
    to_eop     = 1'b0;
    bit_v      = 1'b0;
`ifdef USB_TX_CRC16_EN
    crc_clr    = 1'b0;
    crc_bv     = 1'b0;
    crc_bit    = 1'b0;
    unit_len   = (state_q == CRC) ? 5'd16 : 5'd8;
`else
    unit_len   = 5'd8;
`endif

    if (tx_valid && tx_ready) begin
      hold_d     = tx_data;
      hold_vld_d = 1'b1;
      last_acc_d = tx_last;
    end

    if (state_q != IDLE) cnt_d = boundary ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: if (tx_start) begin
        state_d    = SYNC;
        cnt_d      = '0;
        bidx_d     = 5'd1;
        shift_d    = {8'h00, SYNC_PATTERN};
        dout_d     = SYNC_PATTERN[0];
        en_d       = 1'b1;
        ones_d     = OW'(SYNC_PATTERN[0]);
        busy_d     = 1'b1;
        hold_vld_d = 1'b0;
        last_acc_d = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_clr    = 1'b1;
`endif
      end
`ifdef USB_TX_CRC16_EN
      SYNC, DATA, CRC: if (boundary) begin
`else
      SYNC, DATA: if (boundary) begin
`endif
        // Unit exhausted: decide the next unit before picking the next line bit,
        // so a pending stuff bit is sent ahead of the new unit's first bit.
        if (bidx_q == unit_len) begin
`ifdef USB_TX_CRC16_EN
          if (state_q == CRC) fin = 1'b1;
          else
`endif
          if (hold_vld_q) begin
            shift_d    = {8'h00, hold_q};
            hold_vld_d = 1'b0;
            nxt_state  = DATA;
            nxt_idx    = 5'd0;
          end else if (state_q == DATA && last_acc_q) begin
`ifdef USB_TX_CRC16_EN
            nxt_state = CRC;
            nxt_idx   = 5'd0;
            shift_d   = ~crc_val;
`else
            fin = 1'b1;
`endif
          end else begin
            undr_d = 1'b1;
            to_eop = 1'b1;
          end
        end
        if (fin && !stuff) to_eop = 1'b1;

        if (to_eop) begin
          state_d = EOP_SE0;
          bidx_d  = 5'd0;
          dout_d  = 1'b0;
          en_d    = 1'b0;
          se0_d   = 1'b1;
          ones_d  = '0;
        end else if (stuff) begin
          state_d = nxt_state;
          bidx_d  = nxt_idx;
          dout_d  = 1'b0;
          en_d    = 1'b1;
          ones_d  = '0;
        end else begin
          bit_v   = shift_d[nxt_idx[3:0]];
          state_d = nxt_state;
          bidx_d  = nxt_idx + 5'd1;
          dout_d  = bit_v;
          en_d    = 1'b1;
          ones_d  = bit_v ? ones_q + 1'b1 : '0;
`ifdef USB_TX_CRC16_EN
          crc_bv  = (nxt_state == DATA);
          crc_bit = bit_v;
`endif
        end
      end
      EOP_SE0: if (boundary) begin
        if (bidx_q == 5'(EOP_SE0_BITS - 1)) begin
          state_d = EOP_J;
          bidx_d  = 5'd0;
          se0_d   = 1'b0;
        end else begin
          bidx_d  = bidx_q + 5'd1;
        end
      end
      EOP_J: if (boundary) begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bidx_q     <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      last_acc_q <= 1'b0;
      ones_q     <= '0;
      dout_q     <= 1'b0;
      en_q       <= 1'b0;
      se0_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      undr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      last_acc_q <= last_acc_d;
      ones_q     <= ones_d;
      dout_q     <= dout_d;
      en_q       <= en_d;
      se0_q      <= se0_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      undr_q     <= undr_d;
    end
  end

  assign data_out    = dout_q;
  assign en_nrzi     = en_q;
  assign tx_se0      = se0_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_underrun = undr_q;

endmodule
